// File: rtl/stopwatch_display_pkg.sv
// rtl/stopwatch_display_pkg.sv - shared state, segment and index constants for the stopwatch display
package stopwatch_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_t;

    // Segment patterns are {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [1:0] DIG_SEC_LO = 2'd0;
    localparam logic [1:0] DIG_SEC_HI = 2'd1;
    localparam logic [1:0] DIG_MIN_LO = 2'd2;
    localparam logic [1:0] DIG_MIN_HI = 2'd3;

    localparam int IN_SEC  = 0;
    localparam int IN_SCAN = 1;
    localparam int IN_SS   = 2;
    localparam int IN_CLR  = 3;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD to active-low seven-segment decoder
module seg7_decode
    import stopwatch_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/stopwatch_display.sv
// rtl/stopwatch_display.sv - MM:SS stopwatch with multiplexed active-low seven-segment output
module stopwatch_display
    import stopwatch_display_pkg::*;
#(
    parameter int AN_W        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DP_DIGIT    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_1HZ,
    input  logic            clk_10000HZ,
    input  logic            start_stop,
    input  logic            clear,
    output logic [AN_W-1:0] an,
    output logic [6:0]      seg,
    output logic            dp,
    output logic            running,
    output logic            wrap
);

    localparam logic [AN_W-1:0] AN_ONE = 1;
    localparam logic [1:0]      DP_IDX = 2'(DP_DIGIT);

    logic [3:0]             raw;
    logic [3:0]             pulse;
    logic [SYNC_STAGES-1:0] settle;
    logic                   settled;

    assign raw     = {clear, start_stop, clk_10000HZ, clk_1HZ};
    assign settled = settle[SYNC_STAGES-1];

    // settle marks when the chains hold real samples rather than reset zeros
    always_ff @(posedge clk) begin
        if (rst) settle <= '0;
        else     settle <= {settle[SYNC_STAGES-2:0], 1'b1};
    end

    // A level already high when reset releases is not an edge: arm only after a genuine low.
    for (genvar g = 0; g < 4; g++) begin : g_sync
        logic [SYNC_STAGES-1:0] sr;
        logic                   hist;
        logic                   armed;

        always_ff @(posedge clk) begin
            if (rst) begin
                sr    <= '0;
                hist  <= 1'b0;
                armed <= 1'b0;
            end else begin
                sr    <= {sr[SYNC_STAGES-2:0], raw[g]};
                hist  <= sr[SYNC_STAGES-1];
                armed <= armed | (settled & ~sr[SYNC_STAGES-1]);
            end
        end

        assign pulse[g] = sr[SYNC_STAGES-1] & ~hist & armed;
    end

    sw_state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (pulse[IN_CLR]) begin
            state_d = ST_IDLE;
        end else if (pulse[IN_SS]) begin
            case (state_q)
                ST_RUN:  state_d = ST_PAUSE;
                default: state_d = ST_RUN;
            endcase
        end
    end

    assign running = (state_q == ST_RUN);

    // digit[3:0] = {min_hi, min_lo, sec_hi, sec_lo}
    logic [3:0][3:0] digit;
    logic            count_en;

    assign count_en = pulse[IN_SEC] && (state_q == ST_RUN) && !pulse[IN_CLR];

    always_ff @(posedge clk) begin
        if (rst || pulse[IN_CLR]) begin
            digit <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= count_en && (digit == 16'h5959);
            if (count_en) begin
                if (digit[DIG_SEC_LO] != 4'd9) begin
                    digit[DIG_SEC_LO] <= digit[DIG_SEC_LO] + 4'd1;
                end else begin
                    digit[DIG_SEC_LO] <= 4'd0;
                    if (digit[DIG_SEC_HI] != 4'd5) begin
                        digit[DIG_SEC_HI] <= digit[DIG_SEC_HI] + 4'd1;
                    end else begin
                        digit[DIG_SEC_HI] <= 4'd0;
                        if (digit[DIG_MIN_LO] != 4'd9) begin
                            digit[DIG_MIN_LO] <= digit[DIG_MIN_LO] + 4'd1;
                        end else begin
                            digit[DIG_MIN_LO] <= 4'd0;
                            if (digit[DIG_MIN_HI] != 4'd5) digit[DIG_MIN_HI] <= digit[DIG_MIN_HI] + 4'd1;
                            else                           digit[DIG_MIN_HI] <= 4'd0;
                        end
                    end
                end
            end
        end
    end

    logic [1:0] idx;
    logic [6:0] seg_next;

    seg7_decode u_dec (
        .bcd (digit[idx]),
        .seg (seg_next)
    );

    // anode, segments and dp load together so a digit never shows another digit's pattern
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= 2'd0;
            an  <= '1;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (pulse[IN_SCAN]) begin
            idx <= idx + 2'd1;
            an  <= ~(AN_ONE << idx);
            seg <= seg_next;
            dp  <= (idx != DP_IDX);
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
// tb/tb_stopwatch_display.sv - self-checking bench for stopwatch_display against a seconds-count model
module tb_stopwatch_display;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_1HZ;
    logic       clk_10000HZ;
    logic       start_stop;
    logic       clear;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       running;
    logic       wrap;

    always #5 clk = ~clk;

    stopwatch_display dut (
        .clk         (clk),
        .rst         (rst),
        .clk_1HZ     (clk_1HZ),
        .clk_10000HZ (clk_10000HZ),
        .start_stop  (start_stop),
        .clear       (clear),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .running     (running),
        .wrap        (wrap)
    );

    int total = 0;
    int bad   = 0;

    // model: elapsed seconds, state (0 idle, 1 run, 2 pause), scan position
    int m_secs  = 0;
    int m_state = 0;
    int m_idx   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] exp_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int digit_of(input int i);
        case (i)
            0: return m_secs % 10;
            1: return (m_secs % 60) / 10;
            2: return (m_secs / 60) % 10;
            default: return m_secs / 600;
        endcase
    endfunction

    // raise the chosen inputs for 3 cycles, low for 3; check running/wrap timing each cycle
    task automatic evt(input string tag, input bit t, input bit ss, input bit clr);
        bit old_run, new_run, wr;
        old_run = (m_state == 1);
        wr = 1'b0;
        if (clr) begin
            m_state = 0;
            m_secs  = 0;
        end else begin
            if (t && m_state == 1) begin
                wr = (m_secs == 3599);
                m_secs = (m_secs + 1) % 3600;
            end
            if (ss) m_state = (m_state == 1) ? 2 : 1;
        end
        new_run = (m_state == 1);
        clk_1HZ = t; start_stop = ss; clear = clr;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk({tag, ".running"}, 32'(running), 32'(k >= 3 ? new_run : old_run));
            chk({tag, ".wrap"}, 32'(wrap), 32'(k == 3 && wr));
            if (k == 3) begin
                clk_1HZ = 1'b0; start_stop = 1'b0; clear = 1'b0;
            end
        end
    endtask

    task automatic scan_check(input string tag);
        clk_10000HZ = 1'b1;
        repeat (3) step();
        clk_10000HZ = 1'b0;
        repeat (3) step();
        chk({tag, ".an"}, 32'(an), 32'(8'hFF & ~(8'h01 << m_idx)));
        chk({tag, ".seg"}, 32'(seg), 32'(exp_seg(digit_of(m_idx))));
        chk({tag, ".dp"}, 32'(dp), 32'(m_idx != 2));
        m_idx = (m_idx + 1) % 4;
    endtask

    task automatic scan_all(input string tag);
        repeat (4) scan_check(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".an"}, 32'(an), 32'h0FF);
        chk({tag, ".seg"}, 32'(seg), 32'h07F);
        chk({tag, ".dp"}, 32'(dp), 32'h1);
        chk({tag, ".running"}, 32'(running), 32'h0);
        chk({tag, ".wrap"}, 32'(wrap), 32'h0);
    endtask

    initial begin
        rst = 1'b1; clk_1HZ = 1'b0; clk_10000HZ = 1'b0; start_stop = 1'b0; clear = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        check_reset_vals("reset");
        repeat (4) step();
        check_reset_vals("dark");

        scan_check("scan0");
        scan_check("scan1");
        scan_check("scan2");
        scan_check("scan3");

        evt("start", 1'b0, 1'b1, 1'b0);
        repeat (11) evt("tick11", 1'b1, 1'b0, 1'b0);
        scan_all("show_0011");

        evt("clr_a", 1'b0, 1'b0, 1'b1);
        evt("start_a", 1'b0, 1'b1, 1'b0);
        repeat (5) evt("tick5", 1'b1, 1'b0, 1'b0);
        evt("tick_pause", 1'b1, 1'b1, 1'b0);
        repeat (4) evt("tick_paused", 1'b1, 1'b0, 1'b0);
        evt("tick_resume", 1'b1, 1'b1, 1'b0);
        scan_all("show_0006");

        repeat (144) evt("to_0230", 1'b1, 1'b0, 1'b0);
        evt("pause_0230", 1'b0, 1'b1, 1'b0);
        scan_all("show_0230");
        evt("clr_ss", 1'b0, 1'b1, 1'b1);
        scan_all("show_cleared");

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 6))
                0, 1, 2: evt("rnd_tick", 1'b1, 1'b0, 1'b0);
                3:       evt("rnd_ss", 1'b0, 1'b1, 1'b0);
                4:       evt("rnd_tick_ss", 1'b1, 1'b1, 1'b0);
                5:       evt("rnd_clr", 1'b0, 1'b0, 1'b1);
                default: scan_check("rnd_scan");
            endcase
        end
        scan_all("rnd_final");

        evt("clr_w", 1'b0, 1'b0, 1'b1);
        evt("start_w", 1'b0, 1'b1, 1'b0);
        repeat (3599) evt("to_5959", 1'b1, 1'b0, 1'b0);
        scan_all("show_5959");
        evt("wrap_tick", 1'b1, 1'b0, 1'b0);
        scan_all("show_wrapped");

        evt("clr_r", 1'b0, 1'b0, 1'b1);
        evt("start_r", 1'b0, 1'b1, 1'b0);
        repeat (754) evt("to_1234", 1'b1, 1'b0, 1'b0);
        scan_all("show_1234");

        start_stop = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_state = 0; m_secs = 0; m_idx = 0;
        check_reset_vals("midrst");
        for (int i = 0; i < 10; i++) begin
            step();
            chk("held_ss.running", 32'(running), 32'h0);
        end
        start_stop = 1'b0;
        repeat (4) step();
        chk("held_ss.an", 32'(an), 32'h0FF);
        scan_all("after_rst");
        evt("restart", 1'b0, 1'b1, 1'b0);
        repeat (3) evt("post_tick", 1'b1, 1'b0, 1'b0);
        scan_all("show_0003");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
